// File: rtl/pspin_cfg_pkg.sv
// Shared cluster configuration: command payload and tag types.
package pspin_cfg_pkg;

  localparam int unsigned CMD_NUM_TAGS = 16;
  localparam int unsigned CMD_TAG_W    = $clog2(CMD_NUM_TAGS);

  typedef logic [CMD_TAG_W-1:0] pspin_cmd_tag_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [15:0] len;
  } pspin_cmd_t;

endpackage

// File: rtl/cmd_tag_alloc.sv
// Cluster-wide tag pool: used-tag vector, owner table, lowest-free-tag search.
module cmd_tag_alloc #(
  parameter int unsigned NUM_TAGS   = 16,
  parameter int unsigned NUM_OWNERS = 8,
  localparam int unsigned TAG_W = $clog2(NUM_TAGS),
  localparam int unsigned OWN_W = (NUM_OWNERS > 1) ? $clog2(NUM_OWNERS) : 1,
  localparam int unsigned CNT_W = $clog2(NUM_TAGS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             alloc_i,
  input  logic [OWN_W-1:0] alloc_owner_i,
  input  logic             free_i,
  input  logic [TAG_W-1:0] free_tag_i,
  output logic [TAG_W-1:0] free_tag_o,
  output logic             free_valid_o,
  output logic [OWN_W-1:0] free_owner_o,
  output logic             free_hit_o,
  output logic             free_err_o,
  output logic [CNT_W-1:0] used_cnt_o
);

  logic [NUM_TAGS-1:0] used_q, used_d;
  logic [OWN_W-1:0]    owner_q [NUM_TAGS];

  // Lowest-index free tag and in-use population count.
  always_comb begin
    free_tag_o = '0;
    for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
      if (!used_q[i]) free_tag_o = TAG_W'(i);
    end
    free_valid_o = ~&used_q;
    used_cnt_o   = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      used_cnt_o = used_cnt_o + CNT_W'(used_q[i]);
    end
  end

  // Completion lookup; a free of an unused tag is reported, never applied.
  always_comb begin
    free_hit_o   = free_i & used_q[free_tag_i];
    free_err_o   = free_i & ~used_q[free_tag_i];
    free_owner_o = owner_q[free_tag_i];
    used_d       = used_q;
    if (free_hit_o) used_d[free_tag_i] = 1'b0;
    // The freed tag is still marked used in used_q, so it never equals free_tag_o.
    if (alloc_i && free_valid_o) used_d[free_tag_o] = 1'b1;
  end

  // Tag state and owner table.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      used_q <= '0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) owner_q[i] <= '0;
    end else begin
      used_q <= used_d;
      if (alloc_i && free_valid_o) owner_q[free_tag_o] <= alloc_owner_i;
    end
  end

endmodule

// File: rtl/cluster_cmd_tracker.sv
// Per-cluster command scheduler: round-robin grant gated by per-core credits
// and the tag pool, a one-entry output register and completion routing.
module cluster_cmd_tracker
  import pspin_cfg_pkg::*;
#(
  parameter int unsigned NUM_CORES    = 8,
  parameter int unsigned NUM_TAGS     = 16,
  parameter int unsigned MAX_INFLIGHT = 4,
  localparam int unsigned TAG_W = $clog2(NUM_TAGS),
  localparam int unsigned INF_W = $clog2(NUM_TAGS + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_CORES-1:0]         cmd_valid_i,
  output logic [NUM_CORES-1:0]         cmd_ready_o,
  input  pspin_cmd_t [NUM_CORES-1:0]   cmd_i,
  output logic                         cmd_valid_o,
  input  logic                         cmd_ready_i,
  output pspin_cmd_t                   cmd_o,
  output logic [TAG_W-1:0]             cmd_tag_o,
  input  logic                         cpl_valid_i,
  input  logic [TAG_W-1:0]             cpl_tag_i,
  output logic [NUM_CORES-1:0]         cpl_valid_o,
  output logic [INF_W-1:0]             inflight_o,
  output logic                         idle_o,
  output logic                         err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [CNT_W-1:0]     cnt_q [NUM_CORES];
  logic [CNT_W-1:0]     cnt_d [NUM_CORES];
  logic [PTR_W-1:0]     rr_q, rr_d;
  logic [NUM_CORES-1:0] elig, grant, cpl_valid_d;
  logic [PTR_W-1:0]     grant_idx;
  logic                 accept, out_blocked;
  logic                 cmd_valid_q;
  pspin_cmd_t           cmd_q;
  logic [TAG_W-1:0]     cmd_tag_q;
  logic [NUM_CORES-1:0] cpl_valid_q;
  logic                 err_q;

  logic [TAG_W-1:0] free_tag;
  logic             free_valid, cpl_hit, cpl_err;
  logic [PTR_W-1:0] cpl_owner;
  logic [INF_W-1:0] used_cnt;

  cmd_tag_alloc #(
    .NUM_TAGS   (NUM_TAGS),
    .NUM_OWNERS (NUM_CORES)
  ) u_tag_alloc (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .alloc_i       (accept),
    .alloc_owner_i (grant_idx),
    .free_i        (cpl_valid_i),
    .free_tag_i    (cpl_tag_i),
    .free_tag_o    (free_tag),
    .free_valid_o  (free_valid),
    .free_owner_o  (cpl_owner),
    .free_hit_o    (cpl_hit),
    .free_err_o    (cpl_err),
    .used_cnt_o    (used_cnt)
  );

  // Eligibility: request, spare credit, a free tag and room in the output register.
  always_comb begin
    out_blocked = cmd_valid_q & ~cmd_ready_i;
    for (int unsigned c = 0; c < NUM_CORES; c++) begin
      elig[c] = cmd_valid_i[c] && (cnt_q[c] < CNT_W'(MAX_INFLIGHT)) && free_valid &&
                !out_blocked;
    end
  end

  // Round-robin search over eligible cores starting at rr_q.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    accept    = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      idx = (32'(rr_q) + i) % NUM_CORES;
      if (!accept && elig[idx]) begin
        accept     = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
    rr_d = rr_q;
    if (accept) begin
      if (32'(grant_idx) == NUM_CORES - 1) rr_d = '0;
      else                                 rr_d = grant_idx + PTR_W'(1);
    end
  end

  // Credit counters: cnt + inc - dec, so a same-cycle accept and completion cancel.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CORES; c++) begin
      cnt_d[c] = cnt_q[c];
      if (grant[c]) cnt_d[c] = cnt_d[c] + CNT_W'(1);
      if (cpl_hit && (32'(cpl_owner) == c)) cnt_d[c] = cnt_d[c] - CNT_W'(1);
    end
    cpl_valid_d = '0;
    if (cpl_hit) cpl_valid_d[cpl_owner] = 1'b1;
  end

  // Arbiter pointer, credits, output register, completion pulse and sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      for (int unsigned c = 0; c < NUM_CORES; c++) cnt_q[c] <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      cmd_tag_q   <= '0;
      cpl_valid_q <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
      if (accept) begin
        cmd_valid_q <= 1'b1;
        cmd_q       <= cmd_i[grant_idx];
        cmd_tag_q   <= free_tag;
      end else if (cmd_ready_i) begin
        cmd_valid_q <= 1'b0;
      end
      cpl_valid_q <= cpl_valid_d;
      err_q       <= err_q | cpl_err;
    end
  end

  assign cmd_ready_o = grant;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_o       = cmd_q;
  assign cmd_tag_o   = cmd_tag_q;
  assign cpl_valid_o = cpl_valid_q;
  assign inflight_o  = used_cnt;
  assign idle_o      = (used_cnt == '0) && !cmd_valid_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_cluster_cmd_tracker.sv
// Directed bench for cluster_cmd_tracker with hand-computed expectations.
module tb_cluster_cmd_tracker;
  import pspin_cfg_pkg::*;

  localparam int unsigned NUM_CORES = 8;
  localparam int unsigned NUM_TAGS  = 16;

  logic                       clk_i = 1'b0;
  logic                       rst_ni;
  logic [NUM_CORES-1:0]       cmd_valid_i;
  logic [NUM_CORES-1:0]       cmd_ready_o;
  pspin_cmd_t [NUM_CORES-1:0] cmd_i;
  logic                       cmd_valid_o;
  logic                       cmd_ready_i;
  pspin_cmd_t                 cmd_o;
  logic [3:0]                 cmd_tag_o;
  logic                       cpl_valid_i;
  logic [3:0]                 cpl_tag_i;
  logic [NUM_CORES-1:0]       cpl_valid_o;
  logic [4:0]                 inflight_o;
  logic                       idle_o;
  logic                       err_o;

  int checks = 0;
  int errors = 0;

  cluster_cmd_tracker #(
    .NUM_CORES    (NUM_CORES),
    .NUM_TAGS     (NUM_TAGS),
    .MAX_INFLIGHT (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_i       (cmd_i),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready_i),
    .cmd_o       (cmd_o),
    .cmd_tag_o   (cmd_tag_o),
    .cpl_valid_i (cpl_valid_i),
    .cpl_tag_i   (cpl_tag_i),
    .cpl_valid_o (cpl_valid_o),
    .inflight_o  (inflight_o),
    .idle_o      (idle_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pspin_cmd_t mk(input int c, input int k);
    pspin_cmd_t p;
    p.op   = 4'(c);
    p.addr = 32'h1000_0000 | 32'(c << 8) | 32'(k);
    p.len  = 16'(k + 1);
    return p;
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni      = 1'b0;
    cmd_valid_i = '0;
    cpl_valid_i = 1'b0;
    cpl_tag_i   = '0;
    cmd_ready_i = 1'b1;
    for (int c = 0; c < int'(NUM_CORES); c++) cmd_i[c] = mk(c, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni      = 1'b0;
    cmd_valid_i = '0;
    cmd_ready_i = 1'b1;
    cpl_valid_i = 1'b0;
    cpl_tag_i   = '0;
    for (int c = 0; c < int'(NUM_CORES); c++) cmd_i[c] = mk(c, 0);
    #3;
    check("rst_cmd_valid", 64'(cmd_valid_o), 64'd0);
    check("rst_cmd_o", 64'(cmd_o), 64'd0);
    check("rst_inflight", 64'(inflight_o), 64'd0);
    check("rst_idle", 64'(idle_o), 64'd1);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_cpl", 64'(cpl_valid_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fairness: all cores request, each issued command completed on the next cycle.
    for (int i = 0; i < 9; i++) begin
      cmd_valid_i = '1;
      cpl_valid_i = cmd_valid_o;
      cpl_tag_i   = cmd_tag_o;
      #1;
      check("fair_grant", 64'(cmd_ready_o), 64'(1) << (i % 8));
      if (i > 0) check("fair_cmd", 64'(cmd_o), 64'(mk((i - 1) % 8, 0)));
      @(negedge clk_i);
    end
    cmd_valid_i = '0;
    cpl_valid_i = cmd_valid_o;
    cpl_tag_i   = cmd_tag_o;
    @(negedge clk_i);
    cpl_valid_i = 1'b0;
    check("fair_drain_inflight", 64'(inflight_o), 64'd0);
    check("fair_drain_idle", 64'(idle_o), 64'd1);

    // Single command from core 3 and its completion.
    do_reset();
    cmd_valid_i = 8'h08;
    #1;
    check("single_ready", 64'(cmd_ready_o), 64'h08);
    @(negedge clk_i);
    cmd_valid_i = '0;
    check("single_valid", 64'(cmd_valid_o), 64'd1);
    check("single_tag", 64'(cmd_tag_o), 64'd0);
    check("single_cmd", 64'(cmd_o), 64'(mk(3, 0)));
    check("single_inflight", 64'(inflight_o), 64'd1);
    check("single_idle", 64'(idle_o), 64'd0);
    cpl_valid_i = 1'b1;
    cpl_tag_i   = 4'd0;
    @(negedge clk_i);
    cpl_valid_i = 1'b0;
    check("single_cpl", 64'(cpl_valid_o), 64'h08);
    check("single_cpl_inflight", 64'(inflight_o), 64'd0);
    check("single_cpl_idle", 64'(idle_o), 64'd1);
    @(negedge clk_i);
    check("single_cpl_pulse_end", 64'(cpl_valid_o), 64'd0);

    // Credit limit: core 0 alone gets four tags, then waits for a completion.
    do_reset();
    cmd_valid_i = 8'h01;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("credit_ready", 64'(cmd_ready_o), 64'h01);
      @(negedge clk_i);
      check("credit_tag", 64'(cmd_tag_o), 64'(i));
    end
    #1;
    check("credit_exhausted", 64'(cmd_ready_o), 64'd0);
    check("credit_inflight", 64'(inflight_o), 64'd4);
    cpl_valid_i = 1'b1;
    cpl_tag_i   = 4'd2;
    #1;
    check("credit_no_bypass", 64'(cmd_ready_o), 64'd0);
    @(negedge clk_i);
    cpl_valid_i = 1'b0;
    check("credit_cpl", 64'(cpl_valid_o), 64'h01);
    #1;
    check("credit_regrant", 64'(cmd_ready_o), 64'h01);
    @(negedge clk_i);
    cmd_valid_i = '0;
    check("credit_reuse_tag", 64'(cmd_tag_o), 64'd2);

    // Pool exhaustion: 16 accepts over 8 cores, then a single freed tag.
    do_reset();
    cmd_valid_i = '1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("pool_grant", 64'(cmd_ready_o), 64'(1) << (i % 8));
      @(negedge clk_i);
      check("pool_tag", 64'(cmd_tag_o), 64'(i));
    end
    #1;
    check("pool_full_ready", 64'(cmd_ready_o), 64'd0);
    check("pool_full_inflight", 64'(inflight_o), 64'd16);
    cpl_valid_i = 1'b1;
    cpl_tag_i   = 4'd5;
    @(negedge clk_i);
    cpl_valid_i = 1'b0;
    check("pool_cpl_owner", 64'(cpl_valid_o), 64'h20);
    #1;
    check("pool_one_grant", 64'(cmd_ready_o), 64'h01);
    @(negedge clk_i);
    check("pool_reuse_tag", 64'(cmd_tag_o), 64'd5);
    #1;
    check("pool_full_again", 64'(cmd_ready_o), 64'd0);
    check("pool_inflight_again", 64'(inflight_o), 64'd16);
    cmd_valid_i = '0;

    // Backpressure: held output, no accepts, then drain plus accept together.
    do_reset();
    cmd_ready_i = 1'b0;
    cmd_valid_i = 8'h02;
    #1;
    check("bp_first_ready", 64'(cmd_ready_o), 64'h02);
    @(negedge clk_i);
    cmd_i[1] = mk(1, 1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_stall_ready", 64'(cmd_ready_o), 64'd0);
      check("bp_hold_cmd", 64'(cmd_o), 64'(mk(1, 0)));
      check("bp_hold_tag", 64'(cmd_tag_o), 64'd0);
      check("bp_hold_valid", 64'(cmd_valid_o), 64'd1);
      @(negedge clk_i);
    end
    cmd_ready_i = 1'b1;
    #1;
    check("bp_drain_accept", 64'(cmd_ready_o), 64'h02);
    @(negedge clk_i);
    cmd_valid_i = '0;
    check("bp_next_cmd", 64'(cmd_o), 64'(mk(1, 1)));
    check("bp_next_tag", 64'(cmd_tag_o), 64'd1);
    check("bp_next_valid", 64'(cmd_valid_o), 64'd1);
    @(negedge clk_i);
    check("bp_drained", 64'(cmd_valid_o), 64'd0);
    check("bp_inflight", 64'(inflight_o), 64'd2);

    // Completion on a free tag, then reset in the middle of traffic.
    cpl_valid_i = 1'b1;
    cpl_tag_i   = 4'd7;
    @(negedge clk_i);
    cpl_valid_i = 1'b0;
    check("err_set", 64'(err_o), 64'd1);
    check("err_no_cpl", 64'(cpl_valid_o), 64'd0);
    check("err_inflight", 64'(inflight_o), 64'd2);
    cmd_valid_i = '1;
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_valid", 64'(cmd_valid_o), 64'd0);
    check("async_rst_cmd", 64'(cmd_o), 64'd0);
    check("async_rst_tag", 64'(cmd_tag_o), 64'd0);
    check("async_rst_inflight", 64'(inflight_o), 64'd0);
    check("async_rst_err", 64'(err_o), 64'd0);
    check("async_rst_idle", 64'(idle_o), 64'd1);
    check("async_rst_cpl", 64'(cpl_valid_o), 64'd0);
    @(negedge clk_i);
    rst_ni      = 1'b1;
    cmd_valid_i = '0;
    cpl_valid_i = 1'b1;
    cpl_tag_i   = 4'd0;
    @(negedge clk_i);
    cpl_valid_i = 1'b0;
    check("late_cpl_err", 64'(err_o), 64'd1);
    check("late_cpl_no_pulse", 64'(cpl_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
